booth_r4_mul: RTL and testbench
===============================

Name: booth_r4_mul

Overview:
Parametrised sequential radix-4 Booth multiplier with a start/busy/done handshake, producing the full 2*WIDTH-bit product.
- Signed or unsigned operation is selected per operation.
- Retires 2 multiplier bits per cycle, against 1 bit per cycle for the existing 8-bit shift-and-add unit.
- Intended as the shared multiply engine for the CPU datapath: the ALU issues an operation and stalls on busy.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time check).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; sampled only when the unit is able to accept
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
busy  out  1  high from the accepting edge until the done cycle, inclusive
done  out  1  one-cycle pulse; product valid in this cycle
product  out  2*WIDTH  full product; held until the next completion

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE, counter=0, accumulator=0. Reset overrides everything, including mid-operation; the partial result is discarded.
- Definitions: N = WIDTH/2 + 1 Booth steps.
- Operand capture: on the accepting edge, a and b are extended to WIDTH+2 bits.
  - Sign-extended if is_signed=1, zero-extended otherwise.
  - This makes unsigned operands correct under signed Booth recoding.
- States:
  - IDLE: start=1 -> CALC (capture operands, counter=0, accumulator=0, busy=1). start=0 -> stay.
  - CALC: each cycle performs one Booth step; counter increments. When counter==N-1, go to DONE.
  - DONE: done=1, product <= low 2*WIDTH bits of accumulator, busy=1.
    - start=1 -> CALC with new operands (back-to-back, no idle bubble).
    - Otherwise -> IDLE.
- Booth step: recode triple {b_ext[2i+1], b_ext[2i], b_ext[2i-1]}, with b_ext[-1]=0.
  - Digit set {0, +A, +2A, -A, -2A}.
  - Partial products are WIDTH+3 bits, sign-extended.
  - Accumulator is 2*WIDTH+4 bits, added at weight 4^i (shift-right accumulator or shifted addend, implementer's choice).
  - Result is exact: the true product always fits in 2*WIDTH bits, so truncation loses nothing in either mode.
- Latency: if start is accepted at edge t0, done=1 in the cycle after edge t0+N+1. For WIDTH=16 that is edge t0+10.
- While in CALC, start is ignored, and changes on a, b or is_signed have no effect.
- product changes only on entering DONE; it is stable in IDLE and CALC.
- done is never high for two consecutive cycles unless back-to-back operations were issued, and then only once per operation.
- No combinational path from any input to any output.

Decomposition:
- Shared package mul_pkg holds:
  - booth_sel_t enum: ZERO, POS1, POS2, NEG1, NEG2.
  - Helper constant for N as a function of WIDTH.
- One combinational sub-module, booth_r4_encoder: 3-bit triple -> booth_sel_t. Shared with a future pipelined array multiplier.
- The FSM, counter and accumulator stay in booth_r4_mul.

Test Plan:
1. WIDTH=16, unsigned 0xFFFF*0xFFFF -> product 0xFFFE0001; done one cycle wide, exactly 10 edges after the start edge; busy high throughout.
2. Signed corner cases:
   - 0xFFFF*0xFFFF -> 0x00000001
   - 0x8000*0x8000 -> 0x40000000
   - 0x8000*0x7FFF -> 0xC0008000
3. start re-asserted with 0x0002*0x0003 while the unit is in CALC on 0x00FF*0x0101 (unsigned) -> second request ignored; product 0x0000FFFF.
4. Back-to-back: start held high through the DONE cycle of 0x0010*0x0010, second operation 0x1234*0x0000 -> products 0x00000100 then 0x00000000, done pulses 10 cycles apart.
5. reset pulsed 4 cycles into an operation -> busy=0, done=0, product=0 immediately (asynchronous); a following 0x0003*0xFFFD signed completes -> 0xFFFFFFF7.
6. Randomised 2000 operations, both modes, WIDTH=8 and WIDTH=16 -> product matches the reference model; busy/done timing checked against N.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiply types.
//   booth_sel_t : radix-4 Booth digit selection {0, +A, +2A, -A, -2A}
//   mul_state_t : sequential multiplier control states
//   booth_steps : number of radix-4 digits for a given operand width
package mul_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_sel_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

  // Operands are extended by two bits before recoding, so WIDTH+2 bits
  // are retired two at a time.
  function automatic int booth_steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: one overlapping multiplier triple
// {b[2i+1], b[2i], b[2i-1]} to a digit selection.
//   i_triple : 3-bit multiplier window
//   o_sel    : selected digit
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0] i_triple,
  output booth_sel_t o_sel
);

  always_comb begin
    o_sel = ZERO;
    case (i_triple)
      3'b001, 3'b010: o_sel = POS1;
      3'b011:         o_sel = POS2;
      3'b100:         o_sel = NEG2;
      3'b101, 3'b110: o_sel = NEG1;
      default:        o_sel = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
//   clk, reset           : clock (rising edge), async active-high reset
//   start                : request, accepted in IDLE or DONE
//   is_signed            : two's-complement (1) or unsigned (0) operands
//   a, b                 : multiplicand, multiplier (WIDTH bits)
//   busy                 : accepting edge through the done cycle
//   done                 : one-cycle completion pulse
//   product              : full 2*WIDTH-bit product, held until next completion
module booth_r4_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = booth_steps(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;       // extended operand
  localparam int PW = WIDTH + 3;       // partial product (+/-2A)
  localparam int AW = 2 * WIDTH + 4;   // accumulator

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end

  mul_state_t          r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [EW-1:0]       r_a, r_b;
  logic                r_bm1;
  logic [AW-1:0]       r_acc;
  logic                r_busy, r_done;
  logic [2*WIDTH-1:0]  r_product;

  logic                w_accept;
  logic                w_last;
  booth_sel_t          w_sel;
  logic [PW-1:0]       w_a1, w_a2, w_pp;
  logic [AW-1:0]       w_addend;
  logic                w_busy_nxt, w_done_nxt;
  logic [2*WIDTH-1:0]  w_product_nxt;
  logic                w_acc_unused;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CW'(N - 1));

  // r_b shifts right two bits per step, so the current digit always sits
  // at the bottom with the previous step's top bit held in r_bm1.
  booth_r4_encoder u_enc (
    .i_triple ({r_b[1:0], r_bm1}),
    .o_sel    (w_sel)
  );

  assign w_a1 = {r_a[EW-1], r_a};
  assign w_a2 = {r_a, 1'b0};

  always_comb begin
    w_pp = '0;
    case (w_sel)
      POS1:    w_pp = w_a1;
      POS2:    w_pp = w_a2;
      NEG1:    w_pp = -w_a1;
      NEG2:    w_pp = -w_a2;
      default: w_pp = '0;
    endcase
  end

  // Addend placed at weight 4^cnt; the sign extension makes the
  // accumulator wrap correctly for negative digits.
  assign w_addend = {{(AW-PW){w_pp[PW-1]}}, w_pp} << {r_cnt, 1'b0};

  // Bits above 2*WIDTH only carry sign and are never observed.
  assign w_acc_unused = ^r_acc[AW-1:2*WIDTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output next values. The final accumulator is registered out of DONE,
  // so the done pulse lands one edge after DONE is entered; busy covers it.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != IDLE) || (r_state == DONE);
    w_done_nxt    = (r_state == DONE);
    w_product_nxt = (r_state == DONE) ? r_acc[2*WIDTH-1:0] : r_product;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_product <= w_product_nxt;
    end
  end

  // Datapath: operand capture and one Booth step per CALC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_bm1 <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a   <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
      r_b   <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
      r_bm1 <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == CALC) begin
      r_acc <= r_acc + w_addend;
      r_b   <= {2'b00, r_b[EW-1:2]};
      r_bm1 <= r_b[1];
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_r4_mul.sv
module tb_booth_r4_mul;

  localparam int N16 = 9;
  localparam int N8  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        s16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        s8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  booth_r4_mul #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(s16), .is_signed(sg16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16));

  booth_r4_mul #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .is_signed(sg8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          at;
  } sb_t;

  typedef struct {
    bit          w8;
    bit          sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  sb_t         q16[$], q8[$];
  logic [31:0] last16 = '0;
  logic [15:0] last8  = '0;
  int          n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input bit w8, input bit sg,
                                        input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    if (w8) begin
      x = sg ? longint'($signed(a[7:0])) : longint'({56'd0, a[7:0]});
      y = sg ? longint'($signed(b[7:0])) : longint'({56'd0, b[7:0]});
      p = x * y;
      return {16'h0, p[15:0]};
    end
    x = sg ? longint'($signed(a)) : longint'({48'd0, a});
    y = sg ? longint'($signed(b)) : longint'({48'd0, b});
    p = x * y;
    return p[31:0];
  endfunction

  // Scoreboard monitors: busy must track outstanding work, done must land
  // on the predicted cycle, product must hold between completions.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("busy16", {31'd0, busy16}, {31'd0, q16.size() != 0});
      if (done16) begin
        if (q16.size() == 0) chk("spurious_done16", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = q16.pop_front();
          chk("product16", prod16, e.exp);
          chk("latency16", cyc, e.at);
        end
        last16 = prod16;
      end else chk("hold16", prod16, last16);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("busy8", {31'd0, busy8}, {31'd0, q8.size() != 0});
      if (done8) begin
        if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = q8.pop_front();
          chk("product8", {16'h0, prod8}, e.exp);
          chk("latency8", cyc, e.at);
        end
        last8 = prod8;
      end else chk("hold8", {16'h0, prod8}, {16'h0, last8});
    end
  end

  // Drive one request while the unit is idle; push the expectation at the
  // accepting edge with its predicted done cycle.
  task automatic issue(input bit w8, input bit sg, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    if (w8) begin s8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin s16 = 1'b1; sg16 = sg; a16 = a; b16 = b; end
    @(posedge clk); #1;
    if (w8) q8.push_back('{exp, cyc + N8 + 1});
    else    q16.push_back('{exp, cyc + N16 + 1});
    @(negedge clk);
    s8 = 1'b0; s16 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q16.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    chk("drain_timeout", q16.size() + q8.size(), 32'd0);
    q16.delete(); q8.delete();
    @(negedge clk);
  endtask

  vec_t tbl[12];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[1]  = '{0, 1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[2]  = '{0, 1, 16'h8000, 16'h8000, 32'h40000000};
    tbl[3]  = '{0, 1, 16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[4]  = '{0, 0, 16'h8000, 16'h8000, 32'h40000000};
    tbl[5]  = '{0, 1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[6]  = '{0, 0, 16'h1234, 16'h5678, 32'h06260060};
    tbl[7]  = '{0, 1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA};
    tbl[8]  = '{0, 0, 16'h0000, 16'h1234, 32'h00000000};
    tbl[9]  = '{1, 1, 16'h0080, 16'h0080, 32'h00004000};
    tbl[10] = '{1, 0, 16'h00FF, 16'h00FF, 32'h0000FE01};
    tbl[11] = '{1, 1, 16'h0080, 16'h007F, 32'h0000C080};

    reset = 1'b1;
    s16 = 0; sg16 = 0; a16 = '0; b16 = '0;
    s8  = 0; sg8  = 0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy16", {31'd0, busy16}, 32'd0);
    chk("rst_done16", {31'd0, done16}, 32'd0);
    chk("rst_prod16", prod16, 32'd0);
    chk("rst_prod8", {16'h0, prod8}, 32'd0);
    #2 reset = 1'b0;

    // Table vectors, including the unsigned and signed corners
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].w8, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].exp);
      drain();
    end

    // start re-asserted with other operands during CALC is ignored
    begin
      @(negedge clk);
      s16 = 1'b1; sg16 = 1'b0; a16 = 16'h00FF; b16 = 16'h0101;
      @(posedge clk); #1;
      q16.push_back('{32'h0000FFFF, cyc + N16 + 1});
      @(negedge clk); s16 = 1'b0;
      repeat (2) @(negedge clk);
      s16 = 1'b1; a16 = 16'h0002; b16 = 16'h0003;
      repeat (3) @(negedge clk);
      s16 = 1'b0;
      drain();
    end

    // Back-to-back: start held through the done cycle
    begin
      @(negedge clk);
      s16 = 1'b1; sg16 = 1'b0; a16 = 16'h0010; b16 = 16'h0010;
      @(posedge clk); #1;
      q16.push_back('{32'h00000100, cyc + N16 + 1});
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h0000;
      repeat (N16 + 1) @(posedge clk);
      #1;
      q16.push_back('{32'h00000000, cyc + N16 + 1});
      @(negedge clk); s16 = 1'b0;
      drain();
    end

    // Asynchronous reset mid-operation, then a clean signed operation
    begin
      issue(0, 0, 16'h1234, 16'h5678, 32'h06260060);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy16}, 32'd0);
      chk("midrst_done", {31'd0, done16}, 32'd0);
      chk("midrst_prod", prod16, 32'd0);
      q16.delete(); q8.delete();
      last16 = '0; last8 = '0;
      @(negedge clk);
      #2 reset = 1'b0;
      issue(0, 1, 16'h0003, 16'hFFFD, 32'hFFFFFFF7);
      drain();
    end

    // Randomised operations on both widths against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      bit          rs, w8;
      for (int k = 0; k < 2; k++) begin
        w8 = (k == 1);
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (w8) begin ra[15:8] = '0; rb[15:8] = '0; end
        issue(w8, rs, ra, rb, model(w8, rs, ra, rb));
        drain();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
